sqrt_128b_err_monitor: RTL and testbench

- Downstream checker for the sqrt_128b combinational square-root stage.
- Takes each (radicand, root) pair, computes r*r with an iterative shift-add multiplier, and classifies the root against the exact floor square root as OK, LOW or HIGH.
- Emits a per-sample verdict over a valid/ready handshake and keeps saturating statistics counters.
- Used to score exact and approximated sqrt_128b netlists in hardware.

---
 rtl/sqrt_128b_err_monitor.sv | 144 ++++++++++++++
 tb/tb_sqrt_128b_err_monitor.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sqrt_128b_err_monitor.sv
// rtl/sqrt_128b_err_monitor.sv - scores sqrt_128b roots as OK/LOW/HIGH with saturating statistics
module sqrt_128b_err_monitor #(
    parameter int XW = 128,
    parameter int RW = 64,
    parameter int CW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [XW-1:0] x,
    input  logic [RW-1:0] r,
    output logic          res_valid,
    input  logic          res_ready,
    output logic          res_ok,
    output logic          res_low,
    output logic          res_high,
    input  logic          clear,
    output logic [CW-1:0] cnt_total,
    output logic [CW-1:0] cnt_low,
    output logic [CW-1:0] cnt_high
);
    localparam int BW = $clog2(RW);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_CMP, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   x_q;
    logic [RW-1:0]   r_q;
    logic [XW-1:0]   mcand_q;
    logic [RW-1:0]   mplier_q;
    logic [XW-1:0]   acc_q;
    logic [BW-1:0]   bitcnt_q;
    logic            res_valid_q, res_ok_q, res_low_q, res_high_q;
    logic [CW-1:0]   cnt_total_q, cnt_low_q, cnt_high_q;

    logic            mul_last;
    logic [XW-1:0]   rem;
    logic [XW-1:0]   two_r;
    logic            cmp_low, cmp_high;

    assign mul_last = (bitcnt_q == BW'(RW - 1));

    // acc holds r*r in CMP; rem is only meaningful when acc <= x
    assign rem      = x_q - acc_q;
    assign two_r    = XW'({r_q, 1'b0});
    assign cmp_low  = (acc_q > x_q);
    assign cmp_high = !cmp_low && (rem > two_r);

    assign in_ready  = (state_q == S_IDLE);
    assign res_valid = res_valid_q;
    assign res_ok    = res_ok_q;
    assign res_low   = res_low_q;
    assign res_high  = res_high_q;
    assign cnt_total = cnt_total_q;
    assign cnt_low   = cnt_low_q;
    assign cnt_high  = cnt_high_q;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next-state: accept, RW multiply steps, one compare cycle, wait for consumer
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_MUL;
            S_MUL:   if (mul_last)  state_d = S_CMP;
            S_CMP:                  state_d = S_DONE;
            S_DONE:  if (res_ready) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // operand capture, shift-add multiply and verdict registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            r_q         <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            bitcnt_q    <= '0;
            res_valid_q <= 1'b0;
            res_ok_q    <= 1'b0;
            res_low_q   <= 1'b0;
            res_high_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q      <= x;
                        r_q      <= r;
                        mcand_q  <= XW'(r);
                        mplier_q <= r;
                        acc_q    <= '0;
                        bitcnt_q <= '0;
                    end
                end
                S_MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    bitcnt_q <= bitcnt_q + BW'(1);
                end
                S_CMP: begin
                    res_valid_q <= 1'b1;
                    res_low_q   <= cmp_low;
                    res_high_q  <= cmp_high;
                    res_ok_q    <= !cmp_low && !cmp_high;
                end
                S_DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        res_ok_q    <= 1'b0;
                        res_low_q   <= 1'b0;
                        res_high_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // saturating statistics; clear overrides a same-cycle update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_total_q <= '0;
            cnt_low_q   <= '0;
            cnt_high_q  <= '0;
        end else if (clear) begin
            cnt_total_q <= '0;
            cnt_low_q   <= '0;
            cnt_high_q  <= '0;
        end else if (state_q == S_CMP) begin
            if (cnt_total_q != '1)            cnt_total_q <= cnt_total_q + CW'(1);
            if (cmp_low  && cnt_low_q  != '1) cnt_low_q   <= cnt_low_q + CW'(1);
            if (cmp_high && cnt_high_q != '1) cnt_high_q  <= cnt_high_q + CW'(1);
        end
    end

endmodule

// File: tb/tb_sqrt_128b_err_monitor.sv
// tb/tb_sqrt_128b_err_monitor.sv - self-checking bench for sqrt_128b_err_monitor
module tb_sqrt_128b_err_monitor;
    localparam int XW = 128;
    localparam int RW = 64;
    localparam int CW = 32;
    localparam int V_OK = 0, V_LOW = 1, V_HIGH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [XW-1:0] x = '0;
    logic [RW-1:0] r = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic          res_ok, res_low, res_high;
    logic          clear = 1'b0;
    logic [CW-1:0] cnt_total, cnt_low, cnt_high;

    int checks = 0;
    int errors = 0;

    int            exp_v = V_OK;
    logic [CW-1:0] m_total = '0, m_low = '0, m_high = '0;
    logic          prev_valid = 1'b0, prev_clear = 1'b0;

    sqrt_128b_err_monitor #(.XW(XW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .x(x), .r(r),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_ok(res_ok), .res_low(res_low), .res_high(res_high),
        .clear(clear),
        .cnt_total(cnt_total), .cnt_low(cnt_low), .cnt_high(cnt_high)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [XW-1:0] act, input logic [XW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // classification straight from the squares: r*r > x is LOW, (r+1)^2 <= x is HIGH
    function automatic int verdict(input logic [XW-1:0] xv, input logic [RW-1:0] rv);
        logic [XW+1:0] rr, sq, sq1, xx;
        rr  = {{(XW+2-RW){1'b0}}, rv};
        sq  = rr * rr;
        sq1 = (rr + 1) * (rr + 1);
        xx  = {2'b00, xv};
        if (sq > xx)   return V_LOW;
        if (sq1 <= xx) return V_HIGH;
        return V_OK;
    endfunction

    function automatic logic [2:0] onehot(input int v);
        return (v == V_OK) ? 3'b100 : (v == V_LOW) ? 3'b010 : 3'b001;
    endfunction

    // per-cycle comparison of outputs against the model
    always @(negedge clk) begin
        if (rst) begin
            m_total = '0; m_low = '0; m_high = '0;
            prev_valid = 1'b0; prev_clear = 1'b0;
            chk("rst_flags", {res_valid, res_ok, res_low, res_high}, 0);
            chk("rst_counters", {cnt_total, cnt_low, cnt_high}, 0);
        end else begin
            if (prev_clear) begin
                m_total = '0; m_low = '0; m_high = '0;
            end else if (res_valid && !prev_valid) begin
                if (m_total != '1) m_total = m_total + 1;
                if (exp_v == V_LOW  && m_low  != '1) m_low  = m_low + 1;
                if (exp_v == V_HIGH && m_high != '1) m_high = m_high + 1;
            end
            chk("cnt_total", cnt_total, m_total);
            chk("cnt_low", cnt_low, m_low);
            chk("cnt_high", cnt_high, m_high);
            if (res_valid) chk("flags", {res_ok, res_low, res_high}, onehot(exp_v));
            else           chk("flags_idle", {res_ok, res_low, res_high}, 0);
            prev_valid = res_valid;
            prev_clear = clear;
        end
    end

    task automatic run(input logic [XW-1:0] xv, input logic [RW-1:0] rv, input int lit,
                       input int hold, input bit clr_cmp);
        int n;
        exp_v = verdict(xv, rv);
        chk("model_vs_literal", exp_v, lit);
        chk("in_ready_idle", in_ready, 1);
        x = xv; r = rv; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; x = ~xv; r = ~rv;
        n = 0;
        while (!res_valid && n < 200) begin
            if (clr_cmp && n == RW) clear = 1'b1;
            @(posedge clk); #1;
            n++;
            clear = 1'b0;
        end
        chk("latency", n, RW + 1);
        chk("verdict_literal", {res_ok, res_low, res_high}, onehot(lit));
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            x = XW'(i); r = RW'(i);
            @(posedge clk); #1;
            chk("hold_valid", res_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_flags", {res_ok, res_low, res_high}, onehot(lit));
        end
        in_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("after_hs_valid", res_valid, 0);
        chk("after_hs_in_ready", in_ready, 1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_valid", res_valid, 0);
        chk("reset_cnt", {cnt_total, cnt_low, cnt_high}, 0);

        run(XW'(144), RW'(12), V_OK, 0, 1'b0);
        chk("t1_total", cnt_total, 1);
        chk("t1_low", cnt_low, 0);
        chk("t1_high", cnt_high, 0);

        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        chk("clear_idle", cnt_total, 0);

        run(XW'(143), RW'(12), V_LOW, 0, 1'b0);
        run(XW'(169), RW'(12), V_HIGH, 0, 1'b0);
        chk("t2_total", cnt_total, 2);
        chk("t2_low", cnt_low, 1);
        chk("t2_high", cnt_high, 1);

        run(XW'(168), RW'(12), V_OK, 0, 1'b0);
        run({XW{1'b1}}, {RW{1'b1}}, V_OK, 0, 1'b0);
        run(XW'(0), RW'(0), V_OK, 0, 1'b0);
        run(XW'(1), RW'(0), V_HIGH, 10, 1'b0);
        chk("t3_total", cnt_total, 6);
        chk("t3_high", cnt_high, 2);

        run(XW'(143), RW'(12), V_LOW, 0, 1'b1);
        chk("clr_cmp_total", cnt_total, 0);
        chk("clr_cmp_low", cnt_low, 0);
        chk("clr_cmp_high", cnt_high, 0);

        run(XW'(25), RW'(5), V_OK, 0, 1'b0);
        exp_v = verdict(XW'(144), RW'(12));
        x = XW'(144); r = RW'(12); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_flags", {res_valid, res_ok, res_low, res_high}, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_cnt", {cnt_total, cnt_low, cnt_high}, 0);
        @(posedge clk); #1 rst = 1'b0;

        run(XW'(16), RW'(4), V_OK, 0, 1'b0);
        chk("post_rst_total", cnt_total, 1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
